// File: rtl/subtree_rr_arbiter.sv
// ============================================================================
// Module   : subtree_rr_arbiter
// Purpose  : Round-robin tenure arbiter with a per-tenure beat budget and
//            bubble-free handover. Optional watchdog: ARB_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module subtree_rr_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 255,
    localparam int IDW      = $clog2(NUM_REQ),
    localparam int CW       = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_done,
    input  logic               i_beat,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDW-1:0]     o_gnt_id,
    output logic               o_busy,
    output logic [CW-1:0]      o_beat_cnt,
    output logic               o_err_timeout,
    output logic [IDW-1:0]     o_err_id
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_last_beat = CW'(MAX_BURST - 1);

    state_t             r_state, w_next_state;
    logic [IDW-1:0]     r_id, w_next_id;
    logic [IDW-1:0]     r_ptr, w_next_ptr;
    logic [CW-1:0]      r_cnt, w_next_cnt;
    logic [NUM_REQ-1:0] r_gnt, w_next_gnt;

    logic               w_own;
    logic               w_rel_done;
    logic               w_rel_drop;
    logic               w_rel_burst;
    logic               w_rel_wd;
    logic               w_release;
    logic               w_excl_owner;
    logic               w_grant;
    logic [NUM_REQ-1:0] w_cand;
    logic               w_found;
    logic [IDW-1:0]     w_win;

    assign w_own        = (r_state == ST_OWN);
    assign w_rel_done   = w_own && i_done[r_id];
    assign w_rel_drop   = w_own && !i_req[r_id];
    assign w_rel_burst  = w_own && i_beat && (r_cnt == c_last_beat);
    assign w_release    = w_rel_done || w_rel_drop || w_rel_burst || w_rel_wd;
    // A burst-limited owner stays eligible; the pointer already ranks it last.
    assign w_excl_owner = w_own && (w_rel_done || w_rel_drop || w_rel_wd);

    always_comb begin
        w_cand = i_req;
        if (w_excl_owner) begin
            w_cand[r_id] = 1'b0;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_cand[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_id    = r_id;
        w_next_ptr   = r_ptr;
        w_next_cnt   = r_cnt;
        w_grant      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant = 1'b1;
                end
            end
            ST_OWN: begin
                if (w_release) begin
                    w_next_cnt = '0;
                    if (w_found) begin
                        w_grant = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else if (i_beat) begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_grant) begin
            w_next_state = ST_OWN;
            w_next_id    = w_win;
            w_next_cnt   = '0;
            w_next_ptr   = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
        end
        w_next_gnt = '0;
        if (w_next_state == ST_OWN) begin
            w_next_gnt[w_next_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_id    <= w_next_id;
            r_ptr   <= w_next_ptr;
            r_cnt   <= w_next_cnt;
            r_gnt   <= w_next_gnt;
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam logic [15:0] c_wd_last = 16'(TIMEOUT - 1);

    logic [15:0]    r_wd_cnt;
    logic           r_err;
    logic [IDW-1:0] r_err_id;

    // Expiry is the idle cycle that would bring the count up to TIMEOUT.
    assign w_rel_wd = w_own && !i_beat && (r_wd_cnt == c_wd_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
            r_err_id <= '0;
        end else begin
            if (w_grant || i_beat || !w_own) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
            if (w_rel_wd) begin
                r_err    <= 1'b1;
                r_err_id <= r_id;
            end
        end
    end

    assign o_err_timeout = r_err;
    assign o_err_id      = r_err_id;
`else
    assign w_rel_wd      = 1'b0;
    assign o_err_timeout = 1'b0;
    assign o_err_id      = '0;
`endif

    assign o_gnt      = r_gnt;
    assign o_gnt_id   = r_id;
    assign o_busy     = w_own;
    assign o_beat_cnt = r_cnt;

endmodule

`default_nettype wire

// File: doc/subtree_rr_arbiter.md
# subtree_rr_arbiter

Round-robin arbiter that shares one downstream resource port among the NUM_REQ leaf instances of a generated sub-hierarchy (default 5, one per child slot). It grants exclusive tenure to one requester at a time, bounds each tenure by a beat budget, and re-arbitrates with no bubble cycle. An optional watchdog revokes a stalled tenure and flags the offender.

## Interface
- NUM_REQ, 5, number of requesters (2..16)
- MAX_BURST, 8, maximum accepted beats per tenure (1..255)
- TIMEOUT, 255, watchdog limit in cycles without a beat (1..65535; used only with ARB_WATCHDOG_EN)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request, level, held while tenure is wanted
- done  in  NUM_REQ  per-requester end-of-tenure pulse; only the owner's bit is honoured
- beat  in  1  downstream accepted one beat this cycle
- gnt  out  NUM_REQ  one-hot grant, registered; all-zero when idle
- gnt_id  out  $clog2(NUM_REQ)  index of owner; valid while busy
- busy  out  1  a tenure is active
- beat_cnt  out  $clog2(MAX_BURST+1)  beats accepted in current tenure
- err_timeout  out  1  sticky watchdog flag (tied 0 without ARB_WATCHDOG_EN)
- err_id  out  $clog2(NUM_REQ)  owner revoked by the watchdog (tied 0 without macro)

## Operation
- States: IDLE (gnt=0), OWN (gnt one-hot).
- Reset values: gnt=0, gnt_id=0, busy=0, beat_cnt=0, err_timeout=0, err_id=0, state IDLE, rr pointer=0 (requester 0 highest priority).
- Arbitration: winner = first asserted req bit scanning from pointer upward, modulo NUM_REQ. On grant, pointer := winner+1 mod NUM_REQ.
- IDLE: any req high -> OWN with winner; else stay.
- OWN release event (any of): done[owner]=1; req[owner]=0; beat=1 with beat_cnt==MAX_BURST-1; watchdog expiry.
- On release: re-arbitrate same cycle over current req, excluding the owner when released by done or req drop; a burst-limited owner with req still high remains eligible at lowest priority. Winner -> OWN with beat_cnt=0; no winner -> IDLE.
- beat in OWN: beat_cnt increments (never exceeds MAX_BURST-1 stored; the limiting beat triggers release). beat in IDLE: ignored.
- done on a non-owner bit, or done while IDLE: ignored.
- Simultaneous done and limiting beat: single release; beat counted downstream, beat_cnt cleared.
- gnt_id equals the index of the set gnt bit; gnt never has more than one bit set.

## Timing
- Grant latency: req rising in cycle t while IDLE -> gnt at t+1.
- Handover: release event sampled at cycle r -> new owner's gnt at r+1; zero idle cycles between tenures.
- Owner drops req at r -> its gnt low at r+1.
- Reset asserted mid-tenure: all outputs return to reset values asynchronously; first grant after deassertion follows IDLE rules with pointer 0.
- busy = (state==OWN), registered with gnt.

## Configuration
- ARB_WATCHDOG_EN defined: counter clears on grant and on every beat, increments each OWN cycle without beat; on reaching TIMEOUT it forces release, sets err_timeout (sticky until reset) and captures err_id := owner; the revoked owner is excluded from the same-cycle re-arbitration.
- Not defined: no watchdog logic; tenure ends only by done, req drop or burst limit; err_timeout and err_id tied to 0.

## Test plan
- Reset, req=5'b00100 at cycle 2 -> gnt=5'b00100, gnt_id=2, busy=1 at cycle 3; drop req -> gnt=0, busy=0 next cycle.
- req=5'b11111 held, done pulsed by each owner -> grant order 0,1,2,3,4,0; each handover in one cycle, no gnt=0 gap.
- MAX_BURST=8, req=5'b00011, owner 0 gives 8 consecutive beats -> gnt moves to requester 1 the cycle after the 8th beat; beat_cnt reads 0..7 then 0.
- Single requester 3 held high, 8 beats -> re-granted to 3 next cycle, beat_cnt=0, gnt stays 5'b01000.
- ARB_WATCHDOG_EN, TIMEOUT=4, owner 1 with no beats, req=5'b00110 -> after 4 OWN cycles gnt moves to 2, err_timeout=1, err_id=1, flag stays set.
- done[4] pulsed while owner is 0, and rst_n pulsed low mid-tenure -> done ignored; reset clears gnt, busy, beat_cnt immediately.
